// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    WORD,
    WRITE,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_BYTES    = 2;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - big-endian byte-to-word shift register with byte position counter
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx;

  // First byte shifted in ends up in the MSB after a full word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (load) begin
      word     <= {word[23:0], byte_in};
      byte_idx <= byte_idx + IDX_W'(1);
    end
  end

  assign last_byte = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a checksummed image into instruction memory and releases the core
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t      state, state_next;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [7:0]  csum;
  logic [15:0] n_full;
  logic        n_bad;
  logic        last_word;
  logic        accept;
  logic [31:0] word;
  logic        last_byte;

  assign accept    = in_valid & in_ready;
  assign n_full    = {n_words[15:8], in_data};
  assign n_bad     = (n_full == 16'd0) || (n_full > MAX_N);
  assign last_word = (word_idx == n_words - 16'd1);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == CNT_LO && accept),
    .load      (state == WORD && accept),
    .byte_in   (in_data),
    .word      (word),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CNT_HI;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CNT_HI: if (accept) state_next = CNT_LO;
      CNT_LO: if (accept) state_next = n_bad ? ERR : WORD;
      WORD:   if (accept && last_byte) state_next = WRITE;
      WRITE:  state_next = last_word ? CSUM : WORD;
      CSUM:   if (accept) state_next = (in_data == csum) ? RUN : ERR;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_words  <= '0;
      word_idx <= '0;
      csum     <= '0;
    end else begin
      case (state)
        CNT_HI: if (accept) n_words <= {in_data, 8'h00};
        CNT_LO: if (accept) begin
          n_words[7:0] <= in_data;
          word_idx     <= '0;
          csum         <= '0;
        end
        WORD:   if (accept) csum <= csum ^ in_data;
        WRITE:  if (!last_word) word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

  // Ready is forced low during reset so no byte can be lost across the release edge.
  assign in_ready   = !reset && (state == CNT_HI || state == CNT_LO ||
                                 state == WORD   || state == CSUM);
  assign imem_we    = (state == WRITE);
  assign imem_addr  = imem_we ? (ADDR_W'(word_idx) << 2) : '0;
  assign imem_wdata = imem_we ? word : '0;
  assign cpu_reset  = (state != RUN);
  assign done       = (state == RUN);
  assign error      = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against an image-level model
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int MAX_WORDS = 256;
  localparam int ADDR_W    = 32;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed memory writes, recorded by the monitor only.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          cyc = 0;
  int          done_cyc = -1;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      check("ready_low_in_write", in_ready, 0);
    end
    if (done && !prev_done) done_cyc = cyc;
    prev_done = done;
  end

  logic [31:0] img [0:MAX_WORDS-1];

  function automatic logic [7:0] model_csum(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++)
      x = x ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
    return x;
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b, input int max_gap, output int acc_cyc);
    int gap;
    int waited;
    gap = $urandom_range(0, max_gap);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    acc_cyc = cyc;
    if (!in_ready) begin
      check("byte_accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
  endtask

  int first_cyc;
  int wr_base;

  task automatic load_image(input int n, input logic [7:0] cs, input int max_gap, input int stop_after);
    logic [15:0] n16;
    logic [31:0] w;
    int          sent;
    int          c;
    n16  = 16'(n);
    sent = 0;
    wr_base = wr_addr_q.size();
    send_byte(n16[15:8], max_gap, first_cyc);
    send_byte(n16[7:0], max_gap, c);
    sent = COUNT_BYTES;
    if (n == 0 || n > MAX_WORDS) return;
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (stop_after >= 0 && sent >= stop_after) return;
        send_byte(w[31-8*b -: 8], max_gap, c);
        sent++;
      end
    end
    send_byte(cs, max_gap, c);
  endtask

  // Expected outcome derived from the image alone.
  task automatic verify(input string tag, input int n, input logic [7:0] cs);
    int   exp_writes;
    int   got_writes;
    logic exp_ok;
    repeat (3) @(negedge clk);
    exp_writes = (n == 0 || n > MAX_WORDS) ? 0 : n;
    exp_ok     = (exp_writes != 0) && (cs == model_csum(n));
    got_writes = wr_addr_q.size() - wr_base;
    check({tag, "_nwrites"}, got_writes, exp_writes);
    for (int i = 0; i < exp_writes && i < got_writes; i++) begin
      check({tag, "_addr"}, wr_addr_q[wr_base+i], 32'(i * 4));
      check({tag, "_data"}, wr_data_q[wr_base+i], img[i]);
    end
    check({tag, "_done"}, done, exp_ok);
    check({tag, "_error"}, error, !exp_ok);
    check({tag, "_cpu_reset"}, cpu_reset, !exp_ok);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_we_idle"}, imem_we, 0);
  endtask

  initial begin
    int         n;
    logic [7:0] cs;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_we", imem_we, 0);
    check("reset_addr", imem_addr, 0);
    check("reset_wdata", imem_wdata, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    do_reset();

    // Two-word image, no stalls, with load latency.
    img[0] = 32'h20080005;
    img[1] = 32'h2009000A;
    load_image(2, model_csum(2), 0, -1);
    verify("basic", 2, model_csum(2));
    check("basic_latency", done_cyc - first_cyc, COUNT_BYTES + (BYTES_PER_WORD + 1) * 2 + 1);

    do_reset();
    load_image(2, model_csum(2), 3, -1);
    verify("stalled", 2, model_csum(2));

    do_reset();
    load_image(2, model_csum(2) ^ 8'h5A, 2, -1);
    verify("bad_csum", 2, model_csum(2) ^ 8'h5A);

    do_reset();
    load_image(0, 8'h00, 1, -1);
    verify("n_zero", 0, 8'h00);

    do_reset();
    load_image(MAX_WORDS + 1, 8'h00, 1, -1);
    verify("n_over", MAX_WORDS + 1, 8'h00);

    // Abort partway, then a clean one-word load must succeed.
    do_reset();
    img[0] = 32'h11223344;
    load_image(2, 8'h00, 0, 6);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_we", imem_we, 0);
    reset = 1'b0;
    @(negedge clk);
    img[0] = 32'hAABBCCDD;
    load_image(1, model_csum(1), 1, -1);
    verify("after_rst", 1, model_csum(1));

    do_reset();
    for (int i = 0; i < MAX_WORDS; i++) img[i] = 32'h0040_0000 + 32'(i);
    load_image(MAX_WORDS, model_csum(MAX_WORDS), 0, -1);
    verify("full", MAX_WORDS, model_csum(MAX_WORDS));

    for (int t = 0; t < 8; t++) begin
      do_reset();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      cs = model_csum(n);
      if ($urandom_range(0, 2) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      load_image(n, cs, 3, -1);
      verify($sformatf("rand%0d", t), n, cs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
